// File: rtl/rx_cp_remove.sv
// OFDM receive front stage: strips the cyclic prefix from each symbol of an I/Q burst
// and hands the useful samples to the FFT through a 2-entry registered buffer.
module rx_cp_remove #(
   parameter int N_FFT = 256,
   parameter int N_CP  = 64,
   parameter int DW    = 32
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I,
   input  logic          WE_I,
   input  logic          STB_I,
   input  logic          CYC_I,
   output logic          ACK_O,
   output logic [DW-1:0] DAT_O,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   input  logic          ACK_I,
   output logic          ERR_O
);

   localparam int            N_SYM    = N_FFT + N_CP;
   localparam int            CW       = $clog2(N_SYM);
   localparam logic [CW-1:0] CP_LIM   = CW'(N_CP);
   localparam logic [CW-1:0] CNT_LAST = CW'(N_SYM - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    buf_cnt_q, buf_cnt_d;
   logic [DW-1:0] buf0_q, buf0_d;
   logic [DW-1:0] buf1_q, buf1_d;
   logic          err_q, err_d;

   logic in_req;
   logic in_cp;
   logic accept;
   logic push;
   logic pop;

   // Accept looks only at registered occupancy, so a full buffer refuses input
   // even in a cycle where it pops; reset forces the handshake low immediately.
   always_comb begin
      in_req = CYC_I & STB_I & WE_I;
      in_cp  = (cnt_q < CP_LIM);
      accept = in_req & ~RST_I & (state_q != DRAIN) & (in_cp | (buf_cnt_q < 2'd2));
      push   = accept & ~in_cp;
      pop    = (buf_cnt_q != 2'd0) & ACK_I;
   end

   always_comb begin
      cnt_d = cnt_q;
      err_d = 1'b0;
      if (!CYC_I) begin
         cnt_d = '0;
         err_d = (cnt_q != '0);
      end else if (accept) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // buf0 is always the head; a push with a simultaneous pop only happens at
   // occupancy 1, where the new sample simply replaces the head.
   always_comb begin
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      buf_cnt_d = buf_cnt_q;
      if (push && pop) begin
         buf0_d = DAT_I;
      end else if (pop) begin
         buf0_d    = buf1_q;
         buf_cnt_d = buf_cnt_q - 2'd1;
      end else if (push) begin
         if (buf_cnt_q == 2'd0) begin
            buf0_d = DAT_I;
         end else begin
            buf1_d = DAT_I;
         end
         buf_cnt_d = buf_cnt_q + 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (push) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!CYC_I) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (buf_cnt_d == 2'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         buf_cnt_q <= 2'd0;
         buf0_q    <= '0;
         buf1_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         buf_cnt_q <= buf_cnt_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;
         err_q     <= err_d;
      end
   end

   assign ACK_O = accept;
   assign STB_O = (buf_cnt_q != 2'd0);
   assign WE_O  = STB_O;
   assign DAT_O = STB_O ? buf0_q : '0;
   assign CYC_O = (state_q != IDLE);
   assign ERR_O = err_q;

endmodule

// File: tb/tb_rx_cp_remove.sv
// Self-checking bench for rx_cp_remove: a negedge monitor keeps a scoreboard of
// expected useful samples, while per-scenario tasks check handshakes and framing.
module tb_rx_cp_remove;

   localparam int N_FFT = 256;
   localparam int N_CP  = 64;
   localparam int N_SYM = N_FFT + N_CP;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [DW-1:0] dat_i = '0;
   logic          we_i = 1'b0;
   logic          stb_i = 1'b0;
   logic          cyc_i = 1'b0;
   logic          ack_i = 1'b0;
   logic          ack_o;
   logic [DW-1:0] dat_o;
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic          err_o;

   int            checks = 0;
   int            failures = 0;
   int            pops = 0;
   int            mcnt = 0;
   logic          exp_err = 1'b0;
   logic [DW-1:0] sb[$];

   always #5 clk = ~clk;

   rx_cp_remove #(.N_FFT(N_FFT), .N_CP(N_CP), .DW(DW)) dut (
      .CLK_I(clk),
      .RST_I(rst_i),
      .DAT_I(dat_i),
      .WE_I(we_i),
      .STB_I(stb_i),
      .CYC_I(cyc_i),
      .ACK_O(ack_o),
      .DAT_O(dat_o),
      .CYC_O(cyc_o),
      .STB_O(stb_o),
      .WE_O(we_o),
      .ACK_I(ack_i),
      .ERR_O(err_o)
   );

   // Scoreboard monitor: models the symbol counter from observed accepts, pushes
   // expected useful samples, and compares each popped output in order.
   always @(negedge clk) begin
      logic [DW-1:0] exp_dat;
      if (rst_i) begin
         sb.delete();
         mcnt    = 0;
         exp_err = 1'b0;
      end else begin
         checks++;
         if (err_o !== exp_err) begin
            failures++;
            $display("[TB] FAIL err_pulse: got %0b expected %0b at %0t", err_o, exp_err, $time);
         end
         exp_err = (!cyc_i && mcnt != 0);
         if (!cyc_i) mcnt = 0;
         if (ack_o) begin
            if (mcnt >= N_CP) sb.push_back(dat_i);
            mcnt = (mcnt == N_SYM - 1) ? 0 : mcnt + 1;
         end
         checks++;
         if (we_o !== stb_o) begin
            failures++;
            $display("[TB] FAIL we_eq_stb: got we=%0b expected %0b", we_o, stb_o);
         end
         if (!stb_o) begin
            checks++;
            if (dat_o !== '0) begin
               failures++;
               $display("[TB] FAIL dat_empty: got %0h expected 0", dat_o);
            end
         end else begin
            checks++;
            if (cyc_o !== 1'b1) begin
               failures++;
               $display("[TB] FAIL cyc_with_stb: got %0b expected 1", cyc_o);
            end
         end
         if (stb_o && ack_i) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_output: got %0h expected none", dat_o);
            end else begin
               exp_dat = sb.pop_front();
               if (dat_o !== exp_dat) begin
                  failures++;
                  $display("[TB] FAIL output_data: got %0h expected %0h", dat_o, exp_dat);
               end
            end
         end
      end
   end

   // Presents consecutive indices, holding each until accepted; cycles counts
   // every cycle spent, so an uninterrupted stream gives cycles == n.
   task automatic send(input int first, input int n, output int cycles);
      int i;
      int stall;
      i = 0;
      stall = 0;
      cycles = 0;
      cyc_i = 1'b1;
      we_i  = 1'b1;
      stb_i = 1'b1;
      dat_i = DW'(first);
      while (i < n) begin
         @(negedge clk);
         cycles++;
         if (ack_o) begin
            i++;
            stall = 0;
         end else begin
            stall++;
         end
         @(posedge clk);
         #1;
         dat_i = DW'(first + i);
         if (stall > 2000) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout: got %0d accepts expected %0d", i, n);
            i = n;
         end
      end
      stb_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (!cyc_o) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL %s_cyc_fall: got cyc_o=1 expected 0 within 200 cycles", tag);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s_drain: got %0d pending expected 0", tag, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int c;
      int p0;
      @(negedge clk);
      checks++;
      if ({ack_o, stb_o, cyc_o, we_o, err_o} !== 5'b0 || dat_o !== '0) begin
         failures++;
         $display("[TB] FAIL reset_state: got ack=%0b stb=%0b cyc=%0b we=%0b err=%0b dat=%0h expected all 0",
                  ack_o, stb_o, cyc_o, we_o, err_o, dat_o);
      end
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      ack_i = 1'b0;
      send(0, N_CP + 2, c);
      stb_i = 1'b1;
      dat_i = DW'(N_CP + 2);
      @(negedge clk);
      checks++;
      if (ack_o !== 1'b0 || stb_o !== 1'b1 || dat_o !== DW'(N_CP)) begin
         failures++;
         $display("[TB] FAIL reset_prefill: got ack=%0b stb=%0b dat=%0h expected 0 1 %0h",
                  ack_o, stb_o, dat_o, N_CP);
      end
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      #1;
      checks++;
      if ({ack_o, stb_o, cyc_o, we_o, err_o} !== 5'b0 || dat_o !== '0) begin
         failures++;
         $display("[TB] FAIL reset_midburst: got ack=%0b stb=%0b cyc=%0b we=%0b err=%0b dat=%0h expected all 0",
                  ack_o, stb_o, cyc_o, we_o, err_o, dat_o);
      end
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      cyc_i = 1'b0;
      stb_i = 1'b0;
      @(posedge clk);
      #1;
      ack_i = 1'b1;
      p0 = pops;
      send(1000, N_SYM, c);
      cyc_i = 1'b0;
      wait_idle("reset");
      checks++;
      if (pops - p0 != N_FFT) begin
         failures++;
         $display("[TB] FAIL reset_next_burst: got %0d outputs expected %0d", pops - p0, N_FFT);
      end
   endtask

   task automatic test_one_symbol();
      int c;
      int p0;
      p0 = pops;
      ack_i = 1'b1;
      send(0, N_CP, c);
      checks++;
      if (c != N_CP) begin
         failures++;
         $display("[TB] FAIL cp_ack_cycles: got %0d expected %0d", c, N_CP);
      end
      @(negedge clk);
      checks++;
      if (stb_o !== 1'b0 || cyc_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cp_dropped: got stb=%0b cyc=%0b expected 0 0", stb_o, cyc_o);
      end
      @(posedge clk);
      #1;
      send(N_CP, 1, c);
      @(negedge clk);
      checks++;
      if (stb_o !== 1'b1 || dat_o !== DW'(N_CP)) begin
         failures++;
         $display("[TB] FAIL first_latency: got stb=%0b dat=%0h expected 1 %0h", stb_o, dat_o, N_CP);
      end
      @(posedge clk);
      #1;
      send(N_CP + 1, N_FFT - 1, c);
      checks++;
      if (c != N_FFT - 1) begin
         failures++;
         $display("[TB] FAIL symbol_ack_cycles: got %0d expected %0d", c, N_FFT - 1);
      end
      cyc_i = 1'b0;
      wait_idle("one_symbol");
      checks++;
      if (pops - p0 != N_FFT) begin
         failures++;
         $display("[TB] FAIL one_symbol_count: got %0d expected %0d", pops - p0, N_FFT);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int p0;
      p0 = pops;
      ack_i = 1'b1;
      send(0, 2 * N_SYM, c);
      checks++;
      if (c != 2 * N_SYM) begin
         failures++;
         $display("[TB] FAIL b2b_ack_cycles: got %0d expected %0d", c, 2 * N_SYM);
      end
      cyc_i = 1'b0;
      wait_idle("back_to_back");
      checks++;
      if (pops - p0 != 2 * N_FFT) begin
         failures++;
         $display("[TB] FAIL b2b_count: got %0d expected %0d", pops - p0, 2 * N_FFT);
      end
   endtask

   task automatic test_backpressure();
      int c;
      int p0;
      p0 = pops;
      ack_i = 1'b0;
      send(0, N_CP + 2, c);
      checks++;
      if (c != N_CP + 2) begin
         failures++;
         $display("[TB] FAIL bp_fill_cycles: got %0d expected %0d", c, N_CP + 2);
      end
      stb_i = 1'b1;
      dat_i = DW'(N_CP + 2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (ack_o !== 1'b0 || stb_o !== 1'b1 || dat_o !== DW'(N_CP)) begin
            failures++;
            $display("[TB] FAIL bp_hold: got ack=%0b stb=%0b dat=%0h expected 0 1 %0h",
                     ack_o, stb_o, dat_o, N_CP);
         end
      end
      @(posedge clk);
      #1;
      ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if (ack_o !== 1'b0 || dat_o !== DW'(N_CP)) begin
         failures++;
         $display("[TB] FAIL full_pop_refuse: got ack=%0b dat=%0h expected 0 %0h", ack_o, dat_o, N_CP);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (ack_o !== 1'b1 || dat_o !== DW'(N_CP + 1)) begin
         failures++;
         $display("[TB] FAIL after_pop_accept: got ack=%0b dat=%0h expected 1 %0h", ack_o, dat_o, N_CP + 1);
      end
      @(posedge clk);
      #1;
      send(N_CP + 3, N_SYM - N_CP - 3, c);
      cyc_i = 1'b0;
      wait_idle("backpressure");
      checks++;
      if (pops - p0 != N_FFT) begin
         failures++;
         $display("[TB] FAIL bp_count: got %0d expected %0d", pops - p0, N_FFT);
      end
   endtask

   task automatic test_burst_abort();
      int c;
      int p0;
      p0 = pops;
      ack_i = 1'b1;
      send(0, 100, c);
      cyc_i = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (err_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_err_rise: got %0b expected 1", err_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_err_width: got %0b expected 0", err_o);
      end
      wait_idle("abort");
      checks++;
      if (pops - p0 != 100 - N_CP) begin
         failures++;
         $display("[TB] FAIL abort_count: got %0d expected %0d", pops - p0, 100 - N_CP);
      end
      p0 = pops;
      send(500, 70, c);
      cyc_i = 1'b0;
      wait_idle("abort_restart");
      checks++;
      if (pops - p0 != 70 - N_CP) begin
         failures++;
         $display("[TB] FAIL restart_count: got %0d expected %0d", pops - p0, 70 - N_CP);
      end
   endtask

   task automatic test_cp_only();
      int c;
      ack_i = 1'b1;
      send(0, 30, c);
      cyc_i = 1'b0;
      @(negedge clk);
      checks++;
      if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cp_only_frame: got cyc=%0b stb=%0b expected 0 0", cyc_o, stb_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err_o !== 1'b1 || cyc_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cp_only_err: got err=%0b cyc=%0b expected 1 0", err_o, cyc_o);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_one_symbol();
      test_back_to_back();
      test_backpressure();
      test_burst_abort();
      test_cp_only();
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
